// File: rtl/saber_sched_pkg.sv
// saber_sched_pkg: shared widths and state encoding for the Saber MAC scheduler
package saber_sched_pkg;
  localparam int Q_BITS = 13;
  localparam int S_BITS = 4;
  localparam int ACC_BITS = 16;
  typedef enum logic [2:0] {IDLE, LOAD_S, INIT, MAC, DRAIN, DONE} state_e;
endpackage

// File: rtl/saber_secret_rotator.sv
// saber_secret_rotator: N x 4-bit negacyclic secret buffer with serial load and lane window
//   load_i/load_data_i : shift in one coefficient, index 0 first
//   rot_i              : r[k] <= r[k-1], r[0] <= -r[N-1]
//   blk_i/neg_i        : window r[blk*NUM_MAC + l] per lane, negated when neg_i
//   win_o              : NUM_MAC packed 4-bit lane secrets
module saber_secret_rotator
  import saber_sched_pkg::*;
#(
  parameter int N = 256,
  parameter int NUM_MAC = 8,
  parameter int LOG_N = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [S_BITS-1:0]         load_data_i,
  input  logic                      rot_i,
  input  logic [LOG_N-1:0]          blk_i,
  input  logic                      neg_i,
  output logic [NUM_MAC*S_BITS-1:0] win_o
);
  logic [S_BITS-1:0] r_q [N];
  // Loading shifts toward index 0 so that after N loads r[k] holds s[k].
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < N; k++) r_q[k] <= '0;
    else if (load_i) begin
      r_q[N-1] <= load_data_i;
      for (int k = 0; k < N-1; k++) r_q[k] <= r_q[k+1];
    end else if (rot_i) begin
      r_q[0] <= -r_q[N-1];
      for (int k = 1; k < N; k++) r_q[k] <= r_q[k-1];
    end
  for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
    logic [S_BITS-1:0] v;
    assign v = r_q[LOG_N'(blk_i * NUM_MAC + l)];
    assign win_o[l*S_BITS +: S_BITS] = neg_i ? -v : v;
  end
endmodule

// File: rtl/saber_mac_sched.sv
// saber_mac_sched: sequencer computing c = a*s mod (x^N+1, 2^13) on a NUM_MAC-lane MAC array
//   start/busy/done          : command and status
//   s_valid/s_ready/s_data   : secret stream, index 0 first
//   a_rd_en/a_addr/a_rdata   : a-RAM port, read data one cycle after enable
//   mac_a/mac_secret/mac_acc : operands to the MAC array, mac_result back
//   out_valid/out_ready/out_data/out_last : result stream, index 0..N-1
//   SABER_SCHED_ACC_INIT_EN  : adds acc_in_valid/acc_in_ready/acc_in_data to preload lanes
module saber_mac_sched
  import saber_sched_pkg::*;
#(
  parameter int NUM_MAC = 8,
  parameter int N = 256,
  parameter int LOG_N = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [S_BITS-1:0]           s_data,
  output logic                        a_rd_en,
  output logic [LOG_N-1:0]            a_addr,
  input  logic [Q_BITS-1:0]           a_rdata,
  output logic [Q_BITS-1:0]           mac_a,
  output logic [NUM_MAC*S_BITS-1:0]   mac_secret,
  output logic [NUM_MAC*ACC_BITS-1:0] mac_acc,
  input  logic [NUM_MAC*ACC_BITS-1:0] mac_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Q_BITS-1:0]           out_data,
  output logic                        out_last
`ifdef SABER_SCHED_ACC_INIT_EN
  ,
  input  logic                        acc_in_valid,
  output logic                        acc_in_ready,
  input  logic [Q_BITS-1:0]           acc_in_data
`endif
);
  localparam int LW = $clog2(NUM_MAC);
  localparam logic [LOG_N:0] CNT_N = (LOG_N+1)'(N);
  localparam logic [LOG_N:0] CNT_LAST = (LOG_N+1)'(N-1);
  localparam logic [LOG_N-1:0] BLK_LAST = LOG_N'(N/NUM_MAC-1);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_MAC-1);
  state_e state_q, state_d;
  logic [LOG_N:0] cnt_q, cnt_d;
  logic [LOG_N-1:0] blk_q, blk_d;
  logic neg_q, neg_d;
  logic [Q_BITS-1:0] acc_q [NUM_MAC];
  logic [Q_BITS-1:0] acc_d [NUM_MAC];
  logic [LW-1:0] lane;
  logic [NUM_MAC*S_BITS-1:0] win;
  logic [NUM_MAC*(ACC_BITS-Q_BITS)-1:0] unused_res;
  logic a_vld, s_fire, o_fire;
  assign lane = cnt_q[LW-1:0];
  assign s_fire = s_valid && s_ready;
  assign o_fire = out_valid && out_ready;
  // RAM data for read j arrives on MAC cycle j+1, so cycle 0 carries no operand.
  assign a_vld = state_q == MAC && cnt_q != '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign s_ready = state_q == LOAD_S;
  assign a_rd_en = state_q == MAC && cnt_q < CNT_N;
  assign a_addr = a_rd_en ? cnt_q[LOG_N-1:0] : '0;
  assign mac_a = a_vld ? a_rdata : '0;
  assign mac_secret = a_vld ? win : '0;
  assign out_valid = state_q == DRAIN;
  assign out_data = out_valid ? acc_q[lane] : '0;
  assign out_last = out_valid && blk_q == BLK_LAST && lane == LANE_LAST;
  for (genvar l = 0; l < NUM_MAC; l++) begin : g_acc
    assign mac_acc[l*ACC_BITS +: ACC_BITS] = {{(ACC_BITS-Q_BITS){1'b0}}, acc_q[l]};
    assign unused_res[l*(ACC_BITS-Q_BITS) +: ACC_BITS-Q_BITS] = mac_result[l*ACC_BITS+Q_BITS +: ACC_BITS-Q_BITS];
  end
`ifdef SABER_SCHED_ACC_INIT_EN
  logic acc_fire;
  assign acc_in_ready = state_q == INIT;
  assign acc_fire = acc_in_valid && acc_in_ready;
  always_comb
    for (int l = 0; l < NUM_MAC; l++)
      acc_d[l] = (acc_fire && lane == LW'(l)) ? acc_in_data : a_vld ? mac_result[l*ACC_BITS +: Q_BITS] : acc_q[l];
`else
  always_comb
    for (int l = 0; l < NUM_MAC; l++)
      acc_d[l] = state_q == INIT ? '0 : a_vld ? mac_result[l*ACC_BITS +: Q_BITS] : acc_q[l];
`endif
  saber_secret_rotator #(.N(N), .NUM_MAC(NUM_MAC), .LOG_N(LOG_N)) u_rot (
    .clk(clk), .rst(rst), .load_i(s_fire), .load_data_i(s_data), .rot_i(a_vld),
    .blk_i(blk_q), .neg_i(neg_q), .win_o(win)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    neg_d = neg_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD_S;
      LOAD_S: if (s_fire) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = INIT;
          cnt_d = '0;
          blk_d = '0;
          neg_d = 1'b0;
        end
      end
      INIT: begin
`ifdef SABER_SCHED_ACC_INIT_EN
        if (acc_fire) cnt_d = cnt_q + 1'b1;
        if (acc_fire && lane == LANE_LAST) begin
          state_d = MAC;
          cnt_d = '0;
        end
`else
        state_d = MAC;
`endif
      end
      MAC: begin
        cnt_d = cnt_q + 1'b1;
        // N rotations leave -s in the buffer; the flag restores the sign for the next block.
        if (cnt_q == CNT_N) begin
          state_d = DRAIN;
          cnt_d = '0;
          neg_d = !neg_q;
        end
      end
      DRAIN: if (o_fire) begin
        cnt_d = cnt_q + 1'b1;
        if (lane == LANE_LAST) begin
          cnt_d = '0;
          state_d = blk_q == BLK_LAST ? DONE : INIT;
          blk_d = blk_q == BLK_LAST ? blk_q : blk_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      neg_q <= 1'b0;
      for (int l = 0; l < NUM_MAC; l++) acc_q[l] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      neg_q <= neg_d;
      for (int l = 0; l < NUM_MAC; l++) acc_q[l] <= acc_d[l];
    end
endmodule
